// File: rtl/melody_addr_gen.sv
// Sine-table address generator that plays a fixed 8-note melody.
// Each note sweeps ADDR at its pitch rate for its beat count, then a silent gap follows.
module melody_addr_gen #(
    parameter int COUNT_SIZE = 8,
    parameter int BEAT_DIV   = 12_500_000,
    parameter int GAP_CYC    = 500_000
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    output logic [COUNT_SIZE-1:0] ADDR,
    output logic                  sound_on,
    output logic [3:0]            note_idx,
    output logic [2:0]            mel_pos,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = $clog2(BEAT_DIV);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t                state, state_n;
    logic [9:0]            tone_cnt, tone_n;
    logic [BW-1:0]         beat_cnt, beat_n;
    logic [2:0]            beats_left, left_n;
    logic [GW-1:0]         gap_cnt, gap_n;
    logic [COUNT_SIZE-1:0] addr_n;
    logic [3:0]            note_n;
    logic [2:0]            pos_n;
    logic                  sound_n, busy_n, done_n;
    logic                  advance, enter;
    logic [2:0]            enter_pos;

    function automatic logic [3:0] rom_note(input logic [2:0] p);
        case (p)
            3'd0, 3'd1: return 4'd1;
            3'd2, 3'd3: return 4'd5;
            3'd4, 3'd5: return 4'd6;
            3'd6:       return 4'd5;
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic [2:0] rom_beats(input logic [2:0] p);
        return (p == 3'd6) ? 3'd4 : 3'd2;
    endfunction

    // Tone period minus one; the table sweep period is 256 x (DIV+1) clocks.
    function automatic logic [9:0] pitch_div(input logic [3:0] n);
        case (n)
            4'd1:    return 10'd746;
            4'd2:    return 10'd664;
            4'd3:    return 10'd592;
            4'd4:    return 10'd558;
            4'd5:    return 10'd497;
            4'd6:    return 10'd443;
            4'd7:    return 10'd395;
            4'd8:    return 10'd372;
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic is_pitch(input logic [3:0] n);
        return (n >= 4'd1) && (n <= 4'd8);
    endfunction

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_n   = state;
        tone_n    = tone_cnt;
        beat_n    = beat_cnt;
        left_n    = beats_left;
        gap_n     = gap_cnt;
        addr_n    = ADDR;
        note_n    = note_idx;
        pos_n     = mel_pos;
        done_n    = 1'b0;
        advance   = 1'b0;
        enter     = 1'b0;
        enter_pos = 3'd0;

        if (stop) begin
            state_n = IDLE;
            addr_n  = '0;
            note_n  = 4'd0;
            tone_n  = '0;
            beat_n  = '0;
            left_n  = '0;
            gap_n   = '0;
        end else if (start) begin
            enter = 1'b1;
        end else begin
            case (state)
                PLAY: begin
                    if (is_pitch(note_idx)) begin
                        if (tone_cnt == pitch_div(note_idx)) begin
                            tone_n = '0;
                            addr_n = ADDR + COUNT_SIZE'(1);
                        end else begin
                            tone_n = tone_cnt + 10'd1;
                        end
                    end
                    if (beat_cnt == BEAT_LAST) begin
                        beat_n = '0;
                        left_n = beats_left - 3'd1;
                        if (beats_left == 3'd1) begin
                            if (GAP_CYC == 0) begin
                                advance = 1'b1;
                            end else begin
                                state_n = GAP;
                                gap_n   = '0;
                            end
                        end
                    end else begin
                        beat_n = beat_cnt + BW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) advance = 1'b1;
                    else                     gap_n   = gap_cnt + GW'(1);
                end
                default: ;
            endcase
        end

        // loop is looked at only here, when leaving the last position.
        if (advance) begin
            if (mel_pos != 3'd7) begin
                enter     = 1'b1;
                enter_pos = mel_pos + 3'd1;
            end else if (loop) begin
                enter = 1'b1;
            end else begin
                state_n = IDLE;
                done_n  = 1'b1;
                addr_n  = '0;
                note_n  = 4'd0;
                tone_n  = '0;
                beat_n  = '0;
                left_n  = '0;
                gap_n   = '0;
            end
        end

        if (enter) begin
            state_n = PLAY;
            pos_n   = enter_pos;
            addr_n  = '0;
            tone_n  = '0;
            beat_n  = '0;
            gap_n   = '0;
            left_n  = rom_beats(enter_pos);
            note_n  = rom_note(enter_pos);
        end

        sound_n = (state_n == PLAY) && is_pitch(note_n);
        busy_n  = (state_n != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            tone_cnt   <= '0;
            beat_cnt   <= '0;
            beats_left <= '0;
            gap_cnt    <= '0;
            ADDR       <= '0;
            note_idx   <= 4'd0;
            mel_pos    <= 3'd0;
            sound_on   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            tone_cnt   <= tone_n;
            beat_cnt   <= beat_n;
            beats_left <= left_n;
            gap_cnt    <= gap_n;
            ADDR       <= addr_n;
            note_idx   <= note_n;
            mel_pos    <= pos_n;
            sound_on   <= sound_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_melody_addr_gen.sv
// Scoreboard bench for melody_addr_gen: note-entry and done events are queued when
// start is driven and popped by a monitor as the DUT produces them.
module tb_melody_addr_gen;

    localparam int BD  = 1000;
    localparam int GAP = 10;
    localparam int WBD = 2000;

    logic       clk = 1'b0;
    logic       resetN, start, stop, loop;
    logic [7:0] ADDR;
    logic       sound_on, busy, done;
    logic [3:0] note_idx;
    logic [2:0] mel_pos;

    logic       resetN_w, start_w;
    logic       stop_w = 1'b0;
    logic       loop_w = 1'b0;
    logic [2:0] addr_w;
    logic       sound_w, busy_w, done_w;
    logic [3:0] note_w;
    logic [2:0] pos_w;

    melody_addr_gen #(.COUNT_SIZE(8), .BEAT_DIV(BD), .GAP_CYC(GAP)) dut (
        .clk(clk), .resetN(resetN), .start(start), .stop(stop), .loop(loop),
        .ADDR(ADDR), .sound_on(sound_on), .note_idx(note_idx), .mel_pos(mel_pos),
        .busy(busy), .done(done)
    );

    // Narrow address so the wrap point is reached in a short run.
    melody_addr_gen #(.COUNT_SIZE(3), .BEAT_DIV(WBD), .GAP_CYC(GAP)) dut_w (
        .clk(clk), .resetN(resetN_w), .start(start_w), .stop(stop_w), .loop(loop_w),
        .ADDR(addr_w), .sound_on(sound_w), .note_idx(note_w), .mel_pos(pos_w),
        .busy(busy_w), .done(done_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int c;
        int pos;
        int note;
    } entry_t;

    entry_t exp_q[$];
    int     done_q[$];

    int mel_note  [8] = '{1, 1, 5, 5, 6, 6, 5, 0};
    int mel_beats [8] = '{2, 2, 2, 2, 2, 2, 4, 2};

    task automatic push_run(input int s, input int passes, input bit with_done);
        int t = s;
        for (int k = 0; k < passes; k++) begin
            for (int p = 0; p < 8; p++) begin
                exp_q.push_back('{c: t, pos: p, note: mel_note[p]});
                t += mel_beats[p] * BD + GAP;
            end
        end
        if (with_done) done_q.push_back(t);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_start(input int passes, input bit with_done, output int s);
        @(negedge clk);
        s = cyc + 1;
        push_run(s, passes, with_done);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic       busy_q = 1'b0;
    logic [2:0] pos_q  = 3'd0;
    always @(negedge clk) begin
        entry_t e;
        if (resetN) begin
            if (busy && (!busy_q || mel_pos != pos_q)) begin
                if (exp_q.size() == 0) begin
                    check("entry_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("entry_cyc",  cyc,      e.c);
                    check("entry_pos",  mel_pos,  e.pos);
                    check("entry_note", note_idx, e.note);
                    check("entry_addr", ADDR,     0);
                end
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", done_q.size(), 1);
                else                    check("done_cyc", cyc, done_q.pop_front());
            end
        end
        busy_q = busy;
        pos_q  = mel_pos;
    end

    task automatic main_seq;
        int s;
        // Single pass: start latency, first increments, note 0 timing, rest, done.
        loop = 1'b0;
        pulse_start(1, 1'b1, s);
        check("start_busy",  busy,     1);
        check("start_note",  note_idx, 1);
        check("start_sound", sound_on, 1);
        check("start_addr",  ADDR,     0);
        wait_cyc(s + 746);   check("addr_before_1", ADDR, 0);
        wait_cyc(s + 747);   check("addr_1", ADDR, 1);
        wait_cyc(s + 1493);  check("addr_before_2", ADDR, 1);
        wait_cyc(s + 1494);  check("addr_2", ADDR, 2);
        wait_cyc(s + 1999);  check("p0_last_sound", sound_on, 1);
        wait_cyc(s + 2000);  check("gap_sound", sound_on, 0);
                             check("gap_pos", mel_pos, 0);
        wait_cyc(s + 2009);  check("gap_addr_held", ADDR, 2);
                             check("gap_busy", busy, 1);
        wait_cyc(s + 2010);  check("p1_pos", mel_pos, 1);
                             check("p1_addr", ADDR, 0);
                             check("p1_sound", sound_on, 1);
        wait_cyc(s + 16500); check("rest_addr", ADDR, 0);
                             check("rest_sound", sound_on, 0);
                             check("rest_pos", mel_pos, 7);
                             check("rest_note", note_idx, 0);
        wait_cyc(s + 18080); check("done_pulse", done, 1);
        wait_cyc(s + 18081); check("end_busy", busy, 0);
                             check("end_done_low", done, 0);
                             check("end_addr", ADDR, 0);

        // Looping run: second pass follows directly, loop dropped mid-pass.
        loop = 1'b1;
        pulse_start(2, 1'b1, s);
        wait_cyc(s + 18080); check("loop_pos", mel_pos, 0);
                             check("loop_note", note_idx, 1);
                             check("loop_no_done", done, 0);
                             check("loop_busy", busy, 1);
        wait_cyc(s + 20000); loop = 1'b0;
        wait_cyc(s + 36161); check("loop_end_busy", busy, 0);

        // Stop during position 3.
        pulse_start(1, 1'b1, s);
        wait_cyc(s + 6530);  check("pre_stop_pos", mel_pos, 3);
                             check("pre_stop_sound", sound_on, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy",  busy,     0);
        check("stop_addr",  ADDR,     0);
        check("stop_sound", sound_on, 0);
        check("stop_note",  note_idx, 0);
        check("stop_done",  done,     0);
        exp_q.delete();
        done_q.delete();
        repeat (30) @(negedge clk);

        // start and stop together while playing.
        pulse_start(1, 1'b1, s);
        wait_cyc(s + 100);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("both_busy",  busy,     0);
        check("both_addr",  ADDR,     0);
        check("both_sound", sound_on, 0);
        exp_q.delete();
        done_q.delete();
        repeat (30) @(negedge clk);
    endtask

    task automatic wrap_seq;
        int s, e5;
        @(negedge clk);
        s = cyc + 1;
        start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        e5 = s + 10 * WBD + 5 * GAP;
        wait_cyc(e5);        check("w_pos5", pos_w, 5);
                             check("w_note6", note_w, 6);
        wait_cyc(e5 + 3551); check("w_addr_top", addr_w, 7);
        wait_cyc(e5 + 3552); check("w_addr_wrap", addr_w, 0);
                             check("w_sound", sound_w, 1);
        wait_cyc(e5 + 3996); check("w_addr_after", addr_w, 1);
        #2;
        resetN_w = 1'b0;
        #1;
        check("w_rst_addr",  addr_w,  0);
        check("w_rst_sound", sound_w, 0);
        check("w_rst_note",  note_w,  0);
        check("w_rst_pos",   pos_w,   0);
        check("w_rst_busy",  busy_w,  0);
        check("w_rst_done",  done_w,  0);
        #4;
        resetN_w = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; resetN_w = 1'b0;
        start = 1'b0;  stop = 1'b0; loop = 1'b0; start_w = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr",  ADDR,     0);
        check("rst_sound", sound_on, 0);
        check("rst_note",  note_idx, 0);
        check("rst_pos",   mel_pos,  0);
        check("rst_busy",  busy,     0);
        check("rst_done",  done,     0);
        resetN = 1'b1; resetN_w = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);
        fork
            main_seq();
            wrap_seq();
        join
        check("entry_q_left", exp_q.size(), 0);
        check("done_q_left",  done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
